symbol_pacer: RTL and testbench
===============================

# symbol_pacer

Consumer-side partner of the level controller: paces symbol generation from the controller's `symGenMax` period and feeds symbols to the display/compare logic. It returns `incLevel` once enough symbols have been consumed. It divides `Clk100M` by the current period and emits a pseudo-random 4-bit symbol on each expiry into a small FIFO, which downstream drains with valid/ready. It requests a level increment after every `SYMS_PER_LEVEL` consumed symbols and waits for the controller's `newLevel` acknowledge.

## Interface
- `SYMS_PER_LEVEL`, 10: symbols popped per level-up request (1..255).
- `FIFO_DEPTH`, 4: symbol FIFO entries (power of two, 2..8).
- `LFSR_SEED`, 16'hACE1: reset value of the LFSR (must be nonzero).
- `MIN_PERIOD`, 1000: floor applied to `symGenMax`.

Ports:
- `Clk100M` in 1: system clock, all logic rising-edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `symGenMax` in 32: divider period from the level controller.
- `curLevel` in 4: current level from the level controller.
- `newLevel` in 1: one-cycle acknowledge from the level controller.
- `symReady` in 1: downstream accepts a symbol.
- `symValid` out 1: FIFO non-empty.
- `symData` out 4: FIFO head symbol.
- `incLevel` out 1: one-cycle level-up request.
- `overflow` out 1: sticky, set when a generated symbol is dropped.
- `pendingCount` out 4: FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Reset (async, Reset_n=0):
  - `divCnt`=0, LFSR=`LFSR_SEED`, FIFO empty, `popCnt`=0, state RUN.
  - Outputs `symValid`=0, `symData`=0, `incLevel`=0, `overflow`=0, `pendingCount`=0.
- Divider:
  - Period P = max(`symGenMax`, `MIN_PERIOD`), re-evaluated every cycle, 32-bit unsigned.
  - tick when `divCnt` >= P-1: `divCnt`←0. Otherwise `divCnt`←`divCnt`+1.
  - If P shrinks below the current `divCnt`, tick fires on the next cycle.
  - `newLevel`=1 forces `divCnt`←0 and suppresses any tick that cycle.
- Generator:
  - On tick the LFSR advances one step: 16-bit Fibonacci, taps 16,14,13,11, shift left, feedback into bit 0.
  - The pushed symbol is the new LFSR[3:0].
- FIFO:
  - Push on tick. Pop when `symValid`&&`symReady`.
  - Full with no pop: the symbol is dropped, the LFSR still advances, and `overflow`←1. `overflow` stays set until reset.
  - Full with a simultaneous pop: the push is accepted and no overflow is flagged.
  - Empty with a simultaneous push: no pop.
  - `symData` holds its last value when empty.
- Level FSM (states RUN, WAIT_ACK, MAX):
  - `popCnt` increments on every pop in all states. It is an 8-bit counter.
  - RUN: a pop that makes `popCnt`==`SYMS_PER_LEVEL` resets `popCnt`←0.
    - If `curLevel`==15, go to MAX.
    - Otherwise assert `incLevel` the next cycle and go to WAIT_ACK.
  - WAIT_ACK: `incLevel` is low.
    - Pops keep counting; `popCnt` saturates at `SYMS_PER_LEVEL` and is not cleared here.
    - `newLevel`=1 → RUN. If `popCnt`==`SYMS_PER_LEVEL` on entry to RUN, a new request follows immediately.
  - MAX: `incLevel` stays 0 until reset. Symbols continue.
  - `newLevel` arriving in RUN or MAX has no effect on the FSM; it still restarts the divider.

## Timing
- Tick on cycle k with the FIFO empty: `symValid`=1 and `symData` valid at k+1. FIFO outputs are registered.
- A pop on cycle k updates `pendingCount` and `symValid` at k+1.
- The qualifying pop on cycle k gives `incLevel`=1 during k+1 only.
- The controller's `newLevel` is expected at k+2; the FSM returns to RUN at the edge after `newLevel`.
- First tick after reset release is P cycles later.
- First tick after `newLevel` is P cycles after the `newLevel` cycle.
- Reset mid-operation clears all state immediately, including a pending `incLevel`.

## Test plan
All directed scenarios run with `MIN_PERIOD`=4.

- Period: `symGenMax`=8, `symReady`=1 → `symValid` pulses every 8 cycles. The first symbol is (ACE1 advanced once)[3:0] = 4'h3.
- Overflow: `symGenMax`=4, `symReady`=0, `FIFO_DEPTH`=4 → `pendingCount` reaches 4 after 16 cycles; the 5th tick sets `overflow`=1 and `pendingCount` stays 4.
- Full with simultaneous pop: FIFO full, `symReady` asserted on the tick cycle → `pendingCount` stays 4 and `overflow` stays 0.
- Level request: `SYMS_PER_LEVEL`=3, `curLevel`=2.
  - After the 3rd pop, `incLevel`=1 for one cycle.
  - With `newLevel` held off for 20 cycles, no second pulse occurs even after 3 more pops.
  - Then `newLevel`=1 → `incLevel` pulses 1 cycle after return to RUN.
- Max level: `curLevel`=15 with 3 pops → no `incLevel`. Symbols continue at period P.
- Clamp and reset: `symGenMax`=1 → ticks every 4 cycles. Assert `Reset_n`=0 mid-count → all outputs 0 asynchronously, and the first tick comes 4 cycles after release.

Source files
------------

// File: rtl/symbol_pacer.sv
// -----------------------------------------------------------------------------
// symbol_pacer
//
// Paces pseudo-random symbol generation from the level controller's period,
// buffers the symbols in a small FIFO for the display/compare logic, and asks
// the controller for a level increment after every SYMS_PER_LEVEL consumed
// symbols.
//
// Ports
//   Clk100M      in   system clock, all logic on the rising edge
//   Reset_n      in   asynchronous active-low reset
//   symGenMax    in   [31:0] divider period from the level controller
//   curLevel     in   [3:0]  current level from the level controller
//   newLevel     in   one-cycle acknowledge from the level controller
//   symReady     in   downstream accepts the head symbol
//   symValid     out  FIFO non-empty
//   symData      out  [3:0] FIFO head symbol (holds last value when empty)
//   incLevel     out  one-cycle level-up request
//   overflow     out  sticky flag: a generated symbol was dropped
//   pendingCount out  [3:0] FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module symbol_pacer #(
    parameter int unsigned SYMS_PER_LEVEL = 10,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int unsigned MIN_PERIOD     = 1000
) (
    input  logic        Clk100M,
    input  logic        Reset_n,
    input  logic [31:0] symGenMax,
    input  logic [3:0]  curLevel,
    input  logic        newLevel,
    input  logic        symReady,
    output logic        symValid,
    output logic [3:0]  symData,
    output logic        incLevel,
    output logic        overflow,
    output logic [3:0]  pendingCount
);

    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
    localparam logic [3:0]  DEPTH_C = 4'(FIFO_DEPTH);
    localparam logic [7:0]  SPL_C   = 8'(SYMS_PER_LEVEL);
    localparam logic [3:0]  LVL_TOP = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_MAX      = 2'd2
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Increment that sticks at the limit once reached.
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? v : v + 8'd1;
    endfunction

    logic [31:0]   div_cnt_q, div_cnt_d;
    logic [31:0]   period, period_m1;
    logic          tick;

    logic [15:0]   lfsr_q, lfsr_d;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic [3:0]    remain;
    logic [3:0]    sym_data_q, sym_data_d;
    logic          overflow_q, overflow_d;
    logic          fifo_empty, fifo_full;
    logic          pop, push, drop;

    state_t        state_q, state_d;
    logic [7:0]    pop_cnt_q, pop_cnt_d;
    logic          inc_level_q, inc_level_d;
    logic          level_req;

    // ---- divider: period clamp and tick generation ----
    always_comb begin
        period    = (symGenMax < MIN_P) ? MIN_P : symGenMax;
        period_m1 = period - 32'd1;
        // >= rather than == so a shrinking period fires on the next cycle
        tick      = !newLevel && (div_cnt_q >= period_m1);
        div_cnt_d = (newLevel || tick) ? 32'd0 : div_cnt_q + 32'd1;
        // dropped symbols still advance the sequence
        lfsr_d    = tick ? lfsr_step(lfsr_q) : lfsr_q;
    end

    // ---- symbol FIFO: push on tick, pop on valid/ready ----
    always_comb begin
        fifo_empty = (count_q == 4'd0);
        fifo_full  = (count_q == DEPTH_C);
        pop        = !fifo_empty && symReady;
        // a pop frees the slot the push needs when full
        push       = tick && (!fifo_full || pop);
        drop       = tick && fifo_full && !pop;

        count_d    = count_q + {3'b000, push} - {3'b000, pop};
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | drop;

        // Registered head: entries left after the pop are older than the
        // incoming symbol, so the new symbol only becomes head when nothing
        // else remains.
        remain = count_q - {3'b000, pop};
        if (remain != 4'd0) begin
            sym_data_d = mem_q[rd_ptr_d];
        end else if (push) begin
            sym_data_d = lfsr_d[3:0];
        end else begin
            sym_data_d = sym_data_q;
        end
    end

    always_ff @(posedge Clk100M) begin
        if (push) begin
            mem_q[wr_ptr_q] <= lfsr_d[3:0];
        end
    end

    always_ff @(posedge Clk100M or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt_q  <= 32'd0;
            lfsr_q     <= LFSR_SEED;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            sym_data_q <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            lfsr_q     <= lfsr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sym_data_q <= sym_data_d;
            overflow_q <= overflow_d;
        end
    end

    // ---- level FSM: state register ----
    always_ff @(posedge Clk100M or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_RUN;
            pop_cnt_q   <= 8'd0;
            inc_level_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pop_cnt_q   <= pop_cnt_d;
            inc_level_q <= inc_level_d;
        end
    end

    // ---- level FSM: next state ----
    always_comb begin
        state_d   = state_q;
        pop_cnt_d = pop ? pop_cnt_q + 8'd1 : pop_cnt_q;
        level_req = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                // A full count carried over from WAIT_ACK requests at once;
                // a pop in that same cycle starts the next batch.
                if (pop_cnt_q == SPL_C) begin
                    level_req = 1'b1;
                    pop_cnt_d = pop ? 8'd1 : 8'd0;
                end else if (pop && (pop_cnt_q + 8'd1 == SPL_C)) begin
                    level_req = 1'b1;
                    pop_cnt_d = 8'd0;
                end
                if (level_req) begin
                    state_d = (curLevel == LVL_TOP) ? ST_MAX : ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                pop_cnt_d = pop ? sat_inc(pop_cnt_q, SPL_C) : pop_cnt_q;
                if (newLevel) begin
                    state_d = ST_RUN;
                end
            end
            ST_MAX: begin
                state_d = ST_MAX;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ---- level FSM: outputs ----
    always_comb begin
        inc_level_d = (state_q == ST_RUN) && level_req && (curLevel != LVL_TOP);
    end

    assign symValid     = !fifo_empty;
    assign symData      = sym_data_q;
    assign incLevel     = inc_level_q;
    assign overflow     = overflow_q;
    assign pendingCount = count_q;

endmodule

// File: tb/tb_symbol_pacer.sv
module tb_symbol_pacer;

    localparam int SPL   = 3;
    localparam int DEPTH = 4;
    localparam int MINP  = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        Clk100M = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] symGenMax = 32'd8;
    logic [3:0]  curLevel = 4'd2;
    logic        newLevel = 1'b0;
    logic        symReady = 1'b0;
    logic        symValid;
    logic [3:0]  symData;
    logic        incLevel;
    logic        overflow;
    logic [3:0]  pendingCount;

    int n_checks = 0;
    int n_errors = 0;

    symbol_pacer #(
        .SYMS_PER_LEVEL(SPL),
        .FIFO_DEPTH(DEPTH),
        .LFSR_SEED(SEED),
        .MIN_PERIOD(MINP)
    ) dut (
        .Clk100M(Clk100M),
        .Reset_n(Reset_n),
        .symGenMax(symGenMax),
        .curLevel(curLevel),
        .newLevel(newLevel),
        .symReady(symReady),
        .symValid(symValid),
        .symData(symData),
        .incLevel(incLevel),
        .overflow(overflow),
        .pendingCount(pendingCount)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // ---------------- reference model ----------------
    logic [3:0] exp_q[$];
    longint     m_div;
    logic [15:0] m_lfsr;
    int         m_count;
    bit         m_ovf;
    int         m_popcnt;
    bit         m_wait, m_max, m_inc;

    always @(posedge Clk100M or negedge Reset_n) begin
        longint p;
        bit tk, pp, ps, req;
        if (!Reset_n) begin
            m_div = 0; m_lfsr = SEED; m_count = 0; m_ovf = 0;
            m_popcnt = 0; m_wait = 0; m_max = 0; m_inc = 0;
            exp_q.delete();
        end else begin
            p  = (symGenMax < MINP) ? MINP : longint'(symGenMax);
            tk = !newLevel && (m_div >= p - 1);
            m_div = (newLevel || tk) ? 0 : m_div + 1;
            pp = (m_count > 0) && symReady;
            ps = 0;
            if (tk) begin
                m_lfsr = lfsr_next(m_lfsr);
                if (m_count < DEPTH || pp) begin
                    ps = 1;
                    exp_q.push_back(m_lfsr[3:0]);
                end else begin
                    m_ovf = 1;
                end
            end
            m_count = m_count + int'(ps) - int'(pp);
            req = 0;
            if (m_max) begin
                // no more requests until reset
            end else if (m_wait) begin
                if (pp && m_popcnt < SPL) m_popcnt++;
                if (newLevel) m_wait = 0;
            end else begin
                if (m_popcnt == SPL) begin
                    req = 1;
                    m_popcnt = int'(pp);
                end else if (pp) begin
                    m_popcnt++;
                    if (m_popcnt == SPL) begin
                        req = 1;
                        m_popcnt = 0;
                    end
                end
            end
            m_inc = req && (curLevel != 4'hF);
            if (req) begin
                if (curLevel == 4'hF) m_max = 1;
                else m_wait = 1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Clk100M) begin
        logic [3:0] e;
        if (!Reset_n) begin
            chk("reset_outs", {21'd0, symValid, symData, incLevel, overflow, pendingCount}, 32'd0);
        end else begin
            chk("pendingCount", {28'd0, pendingCount}, 32'(m_count));
            chk("symValid", {31'd0, symValid}, {31'd0, (m_count != 0)});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            chk("incLevel", {31'd0, incLevel}, {31'd0, m_inc});
            if (symValid && symReady) begin
                if (exp_q.size() == 0) begin
                    chk("pop_without_expected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("symData", {28'd0, symData}, {28'd0, e});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(posedge Clk100M); #1;
        Reset_n = 1'b0;
        #1;
        chk("async_reset", {21'd0, symValid, symData, incLevel, overflow, pendingCount}, 32'd0);
        @(posedge Clk100M);
        @(posedge Clk100M); #1;
        Reset_n = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk100M);
            n++;
            @(negedge Clk100M);
            if (symValid) break;
        end
    endtask

    initial begin
        int n, pulses, pops, at, ack_cd;

        // Period: every 8 cycles, first symbol 4'h3
        symGenMax = 32'd8; symReady = 1'b1; curLevel = 4'd2; newLevel = 1'b0;
        do_reset();
        wait_valid(n);
        chk("first_tick_latency", 32'(n), 32'd8);
        chk("first_symbol", {28'd0, symData}, 32'h3);
        wait_valid(n);
        chk("tick_spacing", 32'(n), 32'd8);

        // Overflow
        symGenMax = 32'd4; symReady = 1'b0;
        do_reset();
        repeat (16) @(posedge Clk100M);
        @(negedge Clk100M);
        chk("fill_count", {28'd0, pendingCount}, 32'd4);
        chk("fill_no_ovf", {31'd0, overflow}, 32'd0);
        repeat (4) @(posedge Clk100M);
        @(negedge Clk100M);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {28'd0, pendingCount}, 32'd4);

        // Full with a simultaneous pop
        do_reset();
        repeat (19) @(posedge Clk100M);
        #1 symReady = 1'b1;
        @(posedge Clk100M);
        #1 symReady = 1'b0;
        @(negedge Clk100M);
        chk("fullpop_count", {28'd0, pendingCount}, 32'd4);
        chk("fullpop_no_ovf", {31'd0, overflow}, 32'd0);

        // Level request
        symGenMax = 32'd4; curLevel = 4'd2; symReady = 1'b1;
        do_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk100M);
            n++;
            @(negedge Clk100M);
            if (incLevel) break;
        end
        chk("inc_after_3rd_pop", 32'(n), 32'd13);
        pulses = 0; pops = 0;
        repeat (20) begin
            @(posedge Clk100M);
            @(negedge Clk100M);
            if (incLevel) pulses++;
            if (symValid && symReady) pops++;
        end
        chk("no_pulse_while_waiting", 32'(pulses), 32'd0);
        chk("pops_while_waiting_ge3", {31'd0, (pops >= 3)}, 32'd1);
        newLevel = 1'b1;
        pulses = 0; at = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge Clk100M);
            if (i == 1) begin
                #1 newLevel = 1'b0;
            end
            @(negedge Clk100M);
            if (incLevel) begin
                pulses++;
                if (at == 0) at = i;
            end
        end
        chk("rerequest_pulses", 32'(pulses), 32'd1);
        chk("rerequest_delay", 32'(at), 32'd2);

        // Max level
        curLevel = 4'hF; symReady = 1'b1;
        do_reset();
        pulses = 0; pops = 0;
        repeat (40) begin
            @(posedge Clk100M);
            @(negedge Clk100M);
            if (incLevel) pulses++;
            if (symValid && symReady) pops++;
        end
        chk("max_no_inc", 32'(pulses), 32'd0);
        chk("max_symbols", 32'(pops), 32'd10);

        // Clamp and reset mid-count
        symGenMax = 32'd1; curLevel = 4'd2; symReady = 1'b0;
        do_reset();
        wait_valid(n);
        chk("clamp_latency", 32'(n), 32'd4);
        @(posedge Clk100M);
        do_reset();
        wait_valid(n);
        chk("post_reset_latency", 32'(n), 32'd4);

        // Randomized traffic with an emulated controller
        curLevel = 4'd1; symGenMax = 32'd5;
        do_reset();
        ack_cd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge Clk100M); #1;
            symReady = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 39) == 0) symGenMax = 32'($urandom_range(0, 10));
            if ($urandom_range(0, 149) == 0)
                curLevel = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            newLevel = 1'b0;
            if (incLevel) begin
                ack_cd = $urandom_range(1, 6);
            end else if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) newLevel = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                newLevel = 1'b1;
            end
            if (c == 1500) begin
                newLevel = 1'b0;
                ack_cd = 0;
                curLevel = 4'd3;
                do_reset();
            end
        end
        @(posedge Clk100M); #1;
        newLevel = 1'b0;
        @(negedge Clk100M);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
